// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO controller: op codes, state encoding, divider sizing.
package hilo_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, pick quotient bit.
// Only compiled when HILO_DIV_EN is defined, since nothing else instantiates it.
`ifdef HILO_DIV_EN
module div_step
    import hilo_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_bit,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_nxt_c,
    output logic            q_bit_c
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Trial subtract in XLEN+1 bits so the borrow is the sign bit.
    always_comb begin
        shifted   = {rem, dvd_bit};
        trial     = shifted - {1'b0, dvs};
        q_bit_c   = ~trial[XLEN];
        rem_nxt_c = q_bit_c ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule
`endif

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: single-cycle MULT/MULTU/MTHI/MTLO, multi-cycle DIV/DIVU.
// Macro HILO_DIV_EN enables the iterative divider; without it DIV/DIVU are no-ops.
module hilo_ctrl
    import hilo_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic              acc_c;
    logic              idle_c;
    logic              mul_sgn_c;
    logic [2*XLEN-1:0] a_ext_c;
    logic [2*XLEN-1:0] b_ext_c;
    logic [2*XLEN-1:0] prod_c;
    logic              div_wr_c;
    hilo_t             div_res_c;

    assign acc_c     = start & ~flush;
    assign mul_sgn_c = (op == OP_MULT);
    assign a_ext_c   = {{XLEN{mul_sgn_c & a[XLEN-1]}}, a};
    assign b_ext_c   = {{XLEN{mul_sgn_c & b[XLEN-1]}}, b};
    assign prod_c    = a_ext_c * b_ext_c;

`ifdef HILO_DIV_EN
    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic            q_neg;
    logic            r_neg;
    logic            dz;
    logic            sdiv_c;
    logic            div_acc_c;
    logic [XLEN-1:0] a_mag_c;
    logic [XLEN-1:0] b_mag_c;
    logic [XLEN-1:0] rem_nxt_c;
    logic [XLEN-1:0] quo_fin_c;
    logic            q_bit_c;

    assign idle_c    = (state == ST_IDLE);
    assign sdiv_c    = (op == OP_DIV);
    assign div_acc_c = idle_c & acc_c & is_div(op);
    assign a_mag_c   = (sdiv_c & a[XLEN-1]) ? -a : a;
    assign b_mag_c   = (sdiv_c & b[XLEN-1]) ? -b : b;

    div_step u_step (
        .rem       (rem),
        .dvd_bit   (quo[XLEN-1]),
        .dvs       (dvs),
        .rem_nxt_c (rem_nxt_c),
        .q_bit_c   (q_bit_c)
    );

    assign quo_fin_c = {quo[XLEN-2:0], q_bit_c};
    assign div_wr_c  = (state == ST_RUN) & ~flush & (cnt == '0);

    // Sign-correct the final iteration; a zero divisor forces an all-ones quotient.
    always_comb begin
        div_res_c    = '0;
        div_res_c.hi = r_neg ? -rem_nxt_c : rem_nxt_c;
        div_res_c.lo = dz ? '1 : (q_neg ? -quo_fin_c : quo_fin_c);
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: flush aborts a running divide; DONE always lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (div_acc_c) state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush)           state_nxt = ST_IDLE;
                else if (cnt == '0)  state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Divider datapath: latch magnitudes on accept, one quotient bit per RUN cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            dz    <= 1'b0;
        end else if (div_acc_c) begin
            cnt   <= CNT_W'(DIV_ITER - 1);
            rem   <= '0;
            quo   <= a_mag_c;
            dvs   <= b_mag_c;
            q_neg <= sdiv_c & (a[XLEN-1] ^ b[XLEN-1]);
            r_neg <= sdiv_c & a[XLEN-1];
            dz    <= (b == '0);
        end else if (state == ST_RUN) begin
            rem <= rem_nxt_c;
            quo <= quo_fin_c;
            cnt <= (cnt == '0) ? '0 : cnt - CNT_W'(1);
        end
    end

    assign stall = div_acc_c | (state == ST_RUN);
    assign busy  = (state != ST_IDLE);
`else
    assign idle_c    = 1'b1;
    assign div_wr_c  = 1'b0;
    assign div_res_c = '0;
    assign stall     = 1'b0;
    assign busy      = 1'b0;
`endif

    // Architectural HI/LO: divide completion or a single-cycle op accepted in IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (div_wr_c) begin
            hi <= div_res_c.hi;
            lo <= div_res_c.lo;
        end else if (idle_c & acc_c) begin
            case (op)
                OP_MTHI:          hi <= a;
                OP_MTLO:          lo <= a;
                OP_MULT, OP_MULTU: {hi, lo} <= prod_c;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage HI/LO operation valid this cycle.
- op  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- a  in  32  rs operand (dividend/multiplicand; source for MTHI/MTLO).
- b  in  32  rt operand (divisor/multiplier).
- flush  in  1  squash the EX-stage instruction; aborts any running divide.
- stall  out  1  holds the pipeline front end while a divide is incomplete.
- busy  out  1  state != IDLE.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

Function
REQ-002 The controller SHALL use three states: IDLE, RUN, DONE.
REQ-003 In IDLE, a start with flush=0 SHALL be accepted; a start with flush=1 SHALL be ignored.
REQ-004 MTHI SHALL load hi=a at the next edge; MTLO SHALL load lo=a at the next edge; stall=0.
REQ-005 MULT/MULTU SHALL write {hi,lo} = 64-bit signed/unsigned a*b at the next edge, with stall=0 and the state remaining IDLE.
REQ-006 An accepted DIV/DIVU SHALL cause IDLE->RUN, latch operand magnitudes, and load the iteration counter with 31.
REQ-007 stall SHALL equal (IDLE & start & !flush & op is DIV/DIVU) | RUN.
REQ-008 RUN SHALL perform one restoring quotient bit per cycle; at the edge where counter==0, it SHALL write hi=remainder and lo=quotient and transition to DONE.
REQ-009 An accepted divide at cycle T SHALL hold stall high for cycles T..T+32, with results visible and state DONE in cycle T+33.
REQ-010 DIV SHALL set quotient sign = a[31]^b[31] and remainder sign = a[31]; DIVU SHALL be unsigned; the quotient SHALL truncate toward zero.
REQ-011 A divide by b==0 SHALL take the full latency and write lo=32'hFFFF_FFFF, hi=a for both DIV and DIVU.
REQ-012 DONE SHALL last exactly one cycle with stall=0, ignore start (the held divide leaving EX), and then return to IDLE.
REQ-013 flush in RUN SHALL return the controller to IDLE at the next edge with hi/lo unchanged; stall SHALL be 0 in the following cycle.
REQ-014 A flush in DONE SHALL have no effect on hi/lo.

Reset
REQ-015 resetn=0 SHALL immediately force state=IDLE, counter=0, hi=0, lo=0, stall=0, busy=0, independent of clk.
REQ-016 Reset during RUN SHALL discard the partial divide; no hi/lo write SHALL occur.

Configuration
REQ-017 With HILO_DIV_EN defined, divide SHALL be implemented as specified above.
REQ-018 Without HILO_DIV_EN, DIV/DIVU SHALL be treated as no-ops: hi/lo unchanged, stall=0, state stays IDLE, and the RUN/DONE logic and divider are not instantiated.

Structure
REQ-019 The op encodings, state encoding and DIV_ITER=32 SHALL live in shared package hilo_pkg.
REQ-020 One combinational sub-module div_step SHALL compute a single restoring iteration (shifted partial remainder, trial subtract, quotient bit); sign correction SHALL stay in hilo_ctrl.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- MULT a=32'hFFFF_FFFE (-2), b=3: next edge hi=FFFF_FFFF, lo=FFFF_FFFA; stall never high.
- MULTU a=FFFF_FFFF, b=2: hi=1, lo=FFFF_FFFE.
- DIV a=-7, b=2 at cycle T: stall high T..T+32, DONE at T+33 with lo=FFFF_FFFD (-3), hi=FFFF_FFFF (-1); start held high in T+33 is not re-accepted.
- DIVU a=100, b=0: after 33 cycles, lo=FFFF_FFFF, hi=100.
- DIVU a=10, b=3 with flush at T+10: state IDLE at T+11, stall=0, hi/lo keep prior values; a new MTLO a=5 at T+12 gives lo=5.
- resetn pulsed low at T+5 of a DIV: outputs are immediately 0 and state is IDLE; with HILO_DIV_EN undefined, DIV leaves hi/lo unchanged and stall stays 0.
